// File: rtl/l2_pkg.sv
// l2_pkg: shared types and helpers for the L2 miss-side eviction/fill logic.
//  - evict_state_t : controller FSM states
//  - LINE_W/BEAT_W : cache line and memory beat widths
//  - line_t/beat_t : line and beat vector types
//  - onehot_lowest : reduces any way mask to a single way (lowest set bit, way 0 if empty)
package l2_pkg;

  localparam int LINE_W   = 256;
  localparam int BEAT_W   = 64;
  localparam int MAX_WAYS = 8;

  typedef logic [LINE_W-1:0] line_t;
  typedef logic [BEAT_W-1:0] beat_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_CAPTURE,
    ST_WBACK,
    ST_FILL,
    ST_INSTALL
  } evict_state_t;

  // Empty mask falls back to way 0 so a victim always exists.
  function automatic logic [MAX_WAYS-1:0] onehot_lowest(input logic [MAX_WAYS-1:0] v);
    logic [MAX_WAYS-1:0] r;
    r = MAX_WAYS'(1);
    for (int i = MAX_WAYS - 1; i >= 0; i--) begin
      if (v[i]) r = MAX_WAYS'(1) << i;
    end
    return r;
  endfunction

endpackage

// File: rtl/l2_line_serdes.sv
// l2_line_serdes: BEATS x 64-bit register bank holding one cache line.
// Ports:
//  clk      in   clock
//  load     in   parallel load of line_in into all beats (victim capture)
//  line_in  in   256-bit line to load
//  cap      in   store beat_in into beat[idx] (fill beat returned)
//  idx      in   beat index for capture and for beat_out
//  beat_in  in   64-bit beat from memory
//  beat_out out  beat[idx], used as the write-back beat
//  line_out out  all beats assembled, beat 0 in bits [63:0]
module l2_line_serdes
  import l2_pkg::*;
#(
  parameter int BEATS = 4,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             load,
  input  line_t            line_in,
  input  logic             cap,
  input  logic [CNT_W-1:0] idx,
  input  beat_t            beat_in,
  output beat_t            beat_out,
  output line_t            line_out
);

  beat_t beat_q [BEATS];
  beat_t beat_d [BEATS];

  always_comb begin
    beat_d = beat_q;
    if (load) begin
      for (int i = 0; i < BEATS; i++) beat_d[i] = line_in[i*BEAT_W +: BEAT_W];
    end else if (cap) begin
      beat_d[idx] = beat_in;
    end
  end

  // Pure data storage: no reset, contents are only observed once loaded.
  always_ff @(posedge clk) begin
    beat_q <= beat_d;
  end

  always_comb begin
    line_out = '0;
    for (int i = 0; i < BEATS; i++) line_out[i*BEAT_W +: BEAT_W] = beat_q[i];
  end

  assign beat_out = beat_q[idx];

endmodule

// File: rtl/l2_evict_fill_ctrl.sv
// l2_evict_fill_ctrl: L2 miss handler. Picks the victim way, writes it back
// if valid and dirty, bursts the missing line in, installs it and strobes the
// PLRU update with the filled way.
// Ports:
//  clk, rst_n                     clock, async active-low reset
//  miss_req/miss_addr/miss_ack    requester handshake (level request, ack pulse)
//  fill_line                      filled line, valid with miss_ack
//  lru_way/lru_hit_way/lru_load   PLRU victim in, filled way + update strobe out
//  way_valid/way_dirty            state bits of the indexed set
//  arr_rd_way/arr_rtag/arr_rdata  victim read (data valid one cycle after rd_way)
//  arr_we/arr_wway/arr_wtag/arr_wdata  install write
//  mem_read/mem_write/mem_addr/mem_wdata/mem_rdata/mem_resp  64-bit burst port
// Build option: define L2_PREFER_INVALID_EN to take the lowest invalid way as
// victim whenever the set has one, ignoring lru_way.
module l2_evict_fill_ctrl
  import l2_pkg::*;
#(
  parameter int NUM_WAYS = 8,
  parameter int TAG_W    = 23,
  parameter int IDX_W    = 4,
  parameter int BEATS    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                miss_req,
  input  logic [31:0]         miss_addr,
  output logic                miss_ack,
  output line_t               fill_line,
  input  logic [NUM_WAYS-1:0] lru_way,
  output logic [NUM_WAYS-1:0] lru_hit_way,
  output logic                lru_load,
  input  logic [NUM_WAYS-1:0] way_valid,
  input  logic [NUM_WAYS-1:0] way_dirty,
  output logic [NUM_WAYS-1:0] arr_rd_way,
  input  logic [TAG_W-1:0]    arr_rtag,
  input  line_t               arr_rdata,
  output logic                arr_we,
  output logic [NUM_WAYS-1:0] arr_wway,
  output logic [TAG_W-1:0]    arr_wtag,
  output line_t               arr_wdata,
  output logic                mem_read,
  output logic                mem_write,
  output logic [31:0]         mem_addr,
  output beat_t               mem_wdata,
  input  beat_t               mem_rdata,
  input  logic                mem_resp
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  evict_state_t                state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [TAG_W+IDX_W-1:0]      line_addr_q, line_addr_d;
  logic [NUM_WAYS-1:0]         victim_q, victim_d, victim_pick;
  logic [TAG_W-1:0]            vtag_q, vtag_d;
  logic [TAG_W-1:0]            miss_tag;
  logic [IDX_W-1:0]            idx;
  logic                        victim_dirty, burst_last;
  beat_t                       wr_beat;
  line_t                       asm_line;
  logic                        unused_addr_bits;

  assign unused_addr_bits = ^miss_addr[4:0];
  assign miss_tag     = line_addr_q[TAG_W+IDX_W-1:IDX_W];
  assign idx          = line_addr_q[IDX_W-1:0];
  assign victim_dirty = |(victim_q & way_valid & way_dirty);
  assign burst_last   = mem_resp && (cnt_q == LAST_BEAT);

  always_comb begin
    victim_pick = NUM_WAYS'(onehot_lowest(MAX_WAYS'(lru_way)));
`ifdef L2_PREFER_INVALID_EN
    // An invalid way is never dirty, so this choice also skips write-back.
    if (!(&way_valid)) victim_pick = NUM_WAYS'(onehot_lowest(MAX_WAYS'(~way_valid)));
`else
`endif
  end

  // State register (control only is reset; latched address/victim are data)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    line_addr_q <= line_addr_d;
    victim_q    <= victim_d;
    vtag_q      <= vtag_d;
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    line_addr_d = line_addr_q;
    victim_d    = victim_q;
    vtag_d      = vtag_q;
    case (state_q)
      ST_IDLE: begin
        if (miss_req) begin
          line_addr_d = miss_addr[TAG_W+IDX_W+4:5];
          victim_d    = victim_pick;
          state_d     = ST_SELECT;
        end
      end
      ST_SELECT:  state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        vtag_d  = arr_rtag;
        state_d = victim_dirty ? ST_WBACK : ST_FILL;
      end
      ST_WBACK, ST_FILL: begin
        // Counter wraps to 0 on the last beat, ready for the next burst.
        if (mem_resp) cnt_d = burst_last ? '0 : cnt_q + CNT_W'(1);
        if (burst_last) state_d = (state_q == ST_WBACK) ? ST_FILL : ST_INSTALL;
      end
      ST_INSTALL: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs decode from state only, so reset clears them asynchronously.
  always_comb begin
    miss_ack    = 1'b0;
    fill_line   = '0;
    lru_hit_way = '0;
    lru_load    = 1'b0;
    arr_rd_way  = '0;
    arr_we      = 1'b0;
    arr_wway    = '0;
    arr_wtag    = '0;
    arr_wdata   = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (state_q)
      ST_SELECT: arr_rd_way = victim_q;
      ST_WBACK: begin
        mem_write = 1'b1;
        mem_addr  = {vtag_q, idx, 5'b0};
        mem_wdata = wr_beat;
      end
      ST_FILL: begin
        mem_read = 1'b1;
        mem_addr = {miss_tag, idx, 5'b0};
      end
      ST_INSTALL: begin
        miss_ack    = 1'b1;
        lru_load    = 1'b1;
        arr_we      = 1'b1;
        lru_hit_way = victim_q;
        arr_wway    = victim_q;
        arr_wtag    = miss_tag;
        arr_wdata   = asm_line;
        fill_line   = asm_line;
      end
      default: ;
    endcase
  end

  l2_line_serdes #(
    .BEATS (BEATS),
    .CNT_W (CNT_W)
  ) u_serdes (
    .clk      (clk),
    .load     (state_q == ST_CAPTURE),
    .line_in  (arr_rdata),
    .cap      ((state_q == ST_FILL) && mem_resp),
    .idx      (cnt_q),
    .beat_in  (mem_rdata),
    .beat_out (wr_beat),
    .line_out (asm_line)
  );

endmodule

// File: tb/tb_l2_evict_fill_ctrl.sv
// tb_l2_evict_fill_ctrl: directed and randomized misses against a transaction
// model that predicts victim way, write-back beats, fill line and latency.
module tb_l2_evict_fill_ctrl;

  localparam int NW = 8;
  localparam int TW = 23;
  localparam int IW = 4;
  localparam int B  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          miss_req;
  logic [31:0]   miss_addr;
  logic          miss_ack;
  logic [255:0]  fill_line;
  logic [NW-1:0] lru_way, lru_hit_way, way_valid, way_dirty, arr_rd_way, arr_wway;
  logic          lru_load, arr_we, mem_read, mem_write, mem_resp;
  logic [TW-1:0] arr_rtag, arr_wtag;
  logic [255:0]  arr_rdata, arr_wdata;
  logic [31:0]   mem_addr;
  logic [63:0]   mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  l2_evict_fill_ctrl #(.NUM_WAYS(NW), .TAG_W(TW), .IDX_W(IW), .BEATS(B)) dut (
    .clk(clk), .rst_n(rst_n), .miss_req(miss_req), .miss_addr(miss_addr),
    .miss_ack(miss_ack), .fill_line(fill_line), .lru_way(lru_way),
    .lru_hit_way(lru_hit_way), .lru_load(lru_load), .way_valid(way_valid),
    .way_dirty(way_dirty), .arr_rd_way(arr_rd_way), .arr_rtag(arr_rtag),
    .arr_rdata(arr_rdata), .arr_we(arr_we), .arr_wway(arr_wway),
    .arr_wtag(arr_wtag), .arr_wdata(arr_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Victim rule: lowest set bit of lru_way (way 0 if none); with the
  // prefer-invalid option, lowest invalid way when any exists.
  function automatic logic [NW-1:0] model_victim(input logic [NW-1:0] lru, input logic [NW-1:0] vld);
    logic [NW-1:0] src;
    src = lru;
`ifdef L2_PREFER_INVALID_EN
    if (vld != {NW{1'b1}}) src = ~vld;
`else
    if (vld == 'x) src = lru;
`endif
    for (int i = 0; i < NW; i++) if (src[i]) return NW'(1) << i;
    return NW'(1);
  endfunction

  task automatic run_miss(input logic [31:0] addr, input logic [NW-1:0] lru,
                          input logic [NW-1:0] vld, input logic [NW-1:0] drt,
                          input logic [TW-1:0] rtag, input int per,
                          input bit hold, input int rst_at);
    logic [NW-1:0] ev;
    logic [IW-1:0] ix;
    bit            wb, resp, done;
    logic [255:0]  rd, expl;
    logic [63:0]   mb [B];
    int            wc, rc, gap;
    ev = model_victim(lru, vld);
    wb = |(ev & vld & drt);
    ix = addr[IW+4:5];
    for (int i = 0; i < 8; i++) rd[i*32 +: 32] = $urandom;
    for (int i = 0; i < B; i++) begin
      mb[i] = {$urandom, $urandom};
      expl[i*64 +: 64] = mb[i];
    end
    miss_req = 1'b1; miss_addr = addr; lru_way = lru; way_valid = vld; way_dirty = drt;
    arr_rtag = rtag; arr_rdata = rd; mem_resp = 1'b0;
    wc = 0; rc = 0; gap = 0; done = 1'b0;
    for (int n = 1; n <= 120 && !done; n++) begin
      cyc();
      // Requester inputs wander while busy; only the latched miss matters.
      miss_addr = $urandom; lru_way = NW'($urandom);
      mem_resp = 1'b0; mem_rdata = {$urandom, $urandom};
      chk("rw_exclusive", {mem_read, mem_write} == 2'b11, 1'b0);
      if (arr_rd_way != '0) begin
        chk("rd_way", arr_rd_way, ev);
        chk("rd_way_cycle", n, 1);
      end
      if (mem_write) begin
        if (rst_at >= 0 && wc == rst_at) begin
          rst_n = 1'b0; miss_req = 1'b0;
          #1;
          chk("rst_mem_write", mem_write, 1'b0);
          chk("rst_mem_read", mem_read, 1'b0);
          chk("rst_arr_we", arr_we, 1'b0);
          cyc();
          chk("rst_hold_we", arr_we, 1'b0);
          chk("rst_hold_ack", miss_ack, 1'b0);
          #2 rst_n = 1'b1;
          for (int k = 0; k < 3; k++) begin
            cyc();
            chk("post_rst_idle", {mem_read, mem_write, arr_we, miss_ack, arr_rd_way}, '0);
          end
          return;
        end
        chk("wb_addr", mem_addr, {rtag, ix, 5'b0});
        chk("wb_data", mem_wdata, rd[wc*64 +: 64]);
        resp = (gap == per - 1);
        gap  = resp ? 0 : gap + 1;
        if (resp) wc++;
        mem_resp = resp;
      end else if (mem_read) begin
        chk("fill_addr", mem_addr, {addr[31:IW+5], ix, 5'b0});
        chk("fill_after_wb", wc, wb ? B : 0);
        resp = (gap == per - 1);
        gap  = resp ? 0 : gap + 1;
        if (resp) begin
          mem_rdata = mb[rc];
          rc++;
        end
        mem_resp = resp;
      end else if (miss_ack) begin
        chk("ack_we", arr_we, 1'b1);
        chk("ack_lru_load", lru_load, 1'b1);
        chk("ack_wway", arr_wway, ev);
        chk("ack_hit_way", lru_hit_way, ev);
        chk("ack_wtag", arr_wtag, addr[31:IW+5]);
        chk("ack_fill_line", fill_line, expl);
        chk("ack_wdata", arr_wdata, expl);
        chk("ack_wb_beats", wc, wb ? B : 0);
        chk("ack_fill_beats", rc, B);
        if (per == 1) chk("ack_latency", n, wb ? 3 + 2*B : 3 + B);
        miss_req = hold; miss_addr = addr; lru_way = lru;
        done = 1'b1;
      end else begin
        // Stray responses outside a burst must be ignored.
        mem_resp = 1'($urandom_range(0, 1));
      end
    end
    mem_resp = 1'b0;
    if (!done) begin
      chk("timeout", 0, 1);
      return;
    end
    cyc();
    chk("ack_one_cycle", {miss_ack, arr_we, lru_load}, 3'b000);
    chk("idle_no_mem", {mem_read, mem_write}, 2'b00);
    chk("idle_no_rd", arr_rd_way, '0);
    if (hold) begin
      cyc();
      chk("held_req_new_miss", arr_rd_way, model_victim(lru, vld));
      miss_req = 1'b0;
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      cyc();
    end
  endtask

  initial begin
    rst_n = 1'b0; miss_req = 1'b0; miss_addr = '0; lru_way = '0; way_valid = '0;
    way_dirty = '0; arr_rtag = '0; arr_rdata = '0; mem_rdata = '0; mem_resp = 1'b0;
    #3;
    chk("reset_outputs",
        {miss_ack, lru_load, arr_we, mem_read, mem_write, arr_rd_way, lru_hit_way, arr_wway, mem_addr}, '0);
    chk("reset_fill_line", fill_line, '0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("idle_quiet", {mem_read, mem_write, arr_rd_way}, '0);

    // Clean miss, back-to-back responses
    run_miss(32'h0000_1240, 8'h04, 8'hFF, 8'h00, 23'h5A5A5, 1, 1'b0, -1);
    // Dirty miss on way 7
    run_miss(32'h0ABC_D360, 8'h80, 8'hFF, 8'h80, 23'h1, 1, 1'b0, -1);
    // Response every third cycle, clean and dirty
    run_miss(32'h1234_5680, 8'h02, 8'hFF, 8'h00, 23'h7, 3, 1'b0, -1);
    run_miss(32'h7654_3120, 8'h10, 8'hFF, 8'h10, 23'h3FFFF, 3, 1'b0, -1);
    // Non-one-hot victims
    run_miss(32'h0000_2000, 8'h00, 8'hFF, 8'h00, 23'h2, 1, 1'b0, -1);
    run_miss(32'h0000_3020, 8'h12, 8'hFF, 8'h02, 23'h3, 1, 1'b0, -1);
    // Set with an invalid way
    run_miss(32'h0000_4040, 8'h01, 8'hDF, 8'h01, 23'h4, 1, 1'b0, -1);
    // Request left high after ack starts a second miss
    run_miss(32'h0000_5060, 8'h08, 8'hFF, 8'h00, 23'h5, 1, 1'b1, -1);
    // Reset while the third write-back beat is on the bus
    run_miss(32'h0000_6080, 8'h40, 8'hFF, 8'h40, 23'h6, 1, 1'b0, 2);
    // Recovers normally after that reset
    run_miss(32'h0000_70A0, 8'h20, 8'hFF, 8'h20, 23'h66, 2, 1'b0, -1);

    for (int t = 0; t < 12; t++) begin
      run_miss($urandom, NW'($urandom), NW'($urandom), NW'($urandom), TW'($urandom),
               $urandom_range(1, 3), 1'b0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
